// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen : fixed-frequency PWM generator with button-stepped duty cycle.
//
// Two request inputs step the duty up or down by one step on each rising edge.
// The duty saturates at 0 and DUTY_STEPS and never wraps. Both inputs may be
// asynchronous to clk and are synchronised internally.
//
// Ports
//   clk        in  1  system clock, all logic on the rising edge
//   reset      in  1  synchronous reset, active low
//   i_increase in  1  duty-up request, one step per rising edge
//   i_decrease in  1  duty-down request, one step per rising edge
//   o_pwm      out 1  registered PWM output
// -----------------------------------------------------------------------------

// Per-input synchroniser followed by a registered rising-edge detector.
// rise_o pulses for one clock, SYNC_STAGES+1 clocks after d_i rises.
module pwm_gen_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   rise_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
            sync_d_q <= sync_q[SYNC_STAGES-1];
            rise_q   <= sync_q[SYNC_STAGES-1] & ~sync_d_q;
        end
    end

    assign rise_o = rise_q;
endmodule

module pwm_gen #(
    parameter int PERIOD      = 10,
    parameter int DUTY_STEPS  = 10,
    parameter int DUTY_INIT   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_increase,
    input  logic i_decrease,
    output logic o_pwm
);
    localparam int CW   = $clog2(PERIOD);
    localparam int DW   = $clog2(DUTY_STEPS + 1);
    localparam int TW   = $clog2(PERIOD + 1);
    localparam int STEP = PERIOD / DUTY_STEPS;

    // Lane 0 = increase, lane 1 = decrease.
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0] req;
    logic [NUM_LANES-1:0] rise;

    assign req = {i_decrease, i_increase};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_edge
        pwm_gen_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
            .clk    (clk),
            .reset  (reset),
            .d_i    (req[l]),
            .rise_o (rise[l])
        );
    end

    logic [CW-1:0] cnt_q,       cnt_d;
    logic [DW-1:0] duty_pend_q, duty_pend_d;
    logic [DW-1:0] duty_act_q,  duty_act_d;
    logic          pwm_q,       pwm_d;
    logic [TW-1:0] threshold;
    logic          last;

    assign last      = (cnt_q == CW'(PERIOD - 1));
    assign threshold = TW'(duty_act_q) * TW'(STEP);

    always_comb begin
        cnt_d       = last ? '0 : cnt_q + 1'b1;
        duty_pend_d = duty_pend_q;
        duty_act_d  = duty_act_q;

        // Simultaneous up and down requests cancel out.
        if (rise[0] && !rise[1]) begin
            if (duty_pend_q != DW'(DUTY_STEPS)) duty_pend_d = duty_pend_q + 1'b1;
        end else if (rise[1] && !rise[0]) begin
            if (duty_pend_q != '0) duty_pend_d = duty_pend_q - 1'b1;
        end

        // Pending duty only takes effect at a period boundary, so a period
        // in flight is never shortened or stretched (no runt pulses).
        if (last) duty_act_d = duty_pend_q;

        pwm_d = (TW'(cnt_q) < threshold);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            duty_pend_q <= DW'(DUTY_INIT);
            duty_act_q  <= DW'(DUTY_INIT);
            pwm_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            pwm_q       <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;
endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen : self-checking bench for pwm_gen (default parameters).
// Table vectors apply request pulses and push the expected high time per
// period; after settling, a 10-clock window of o_pwm is measured and compared
// against the popped expectation. Hand-written sequences cover the
// period-boundary and mid-period reset corner cases.
// -----------------------------------------------------------------------------
module tb_pwm_gen;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic inc = 1'b0;
    logic dec = 1'b0;
    logic o_pwm;

    always #5 clk = ~clk;

    pwm_gen dut (
        .clk        (clk),
        .reset      (reset),
        .i_increase (inc),
        .i_decrease (dec),
        .o_pwm      (o_pwm)
    );

    typedef struct {
        string name;
        int    n_inc;
        int    n_dec;
        bit    hold;
        bit    both;
        int    exp_hi;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One request pulse of len clocks, then 9 clocks low (100 ns spacing).
    task automatic pulse(input bit i, input bit d, input int len);
        inc = i;
        dec = d;
        clks(len);
        inc = 1'b0;
        dec = 1'b0;
        clks(9);
    endtask

    // Count high samples over 10 consecutive clocks (one full period).
    task automatic window(output int hi);
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hi += int'(o_pwm);
        end
    endtask

    // Advance until o_pwm is sampled going 0 -> 1; bounded.
    task automatic wait_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = o_pwm;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (!prev && o_pwm) ok = 1'b1;
            prev = o_pwm;
        end
    endtask

    // Called at a rise sample; returns clocks to the next rise (-1 on timeout).
    task automatic rise_dist(output int d);
        logic prev;
        bit   found;
        prev  = 1'b1;
        found = 1'b0;
        d     = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            d++;
            if (!prev && o_pwm) found = 1'b1;
            prev = o_pwm;
        end
        if (!found) d = -1;
    endtask

    vec_t vecs[$];

    initial begin
        int hi;
        int d;
        bit ok;

        vecs = '{
            '{"inc to 6",        1,  0, 1'b0, 1'b0, 6},
            '{"inc to 7",        1,  0, 1'b0, 1'b0, 7},
            '{"inc to 8",        1,  0, 1'b0, 1'b0, 8},
            '{"dec x6 to 2",     0,  6, 1'b0, 1'b0, 2},
            '{"inc x12 sat 10",  12, 0, 1'b0, 1'b0, 10},
            '{"dec x12 sat 0",   0, 12, 1'b0, 1'b0, 0},
            '{"inc x5 to 5",     5,  0, 1'b0, 1'b0, 5},
            '{"held inc once",   0,  0, 1'b1, 1'b0, 6},
            '{"inc+dec no chg",  0,  0, 1'b0, 1'b1, 6}
        };

        // Reset held for 3 clocks: output low.
        clks(3);
        check("reset hold o_pwm", int'(o_pwm), 0);
        reset = 1'b1;
        exp_q.push_back(5);
        clks(5);
        window(hi);
        check("reset duty 50%", hi, exp_q.pop_front());

        foreach (vecs[v]) begin
            if (vecs[v].hold) begin
                inc = 1'b1;
                clks(50);
                inc = 1'b0;
                clks(10);
            end else if (vecs[v].both) begin
                pulse(1'b1, 1'b1, 1);
            end else begin
                repeat (vecs[v].n_inc) pulse(1'b1, 1'b0, 1);
                repeat (vecs[v].n_dec) pulse(1'b0, 1'b1, 1);
            end
            exp_q.push_back(vecs[v].exp_hi);
            clks(25);
            window(hi);
            check(vecs[v].name, hi, exp_q.pop_front());
        end

        // Mid-period duty change: current period keeps old duty.
        reset = 1'b0;
        clks(3);
        reset = 1'b1;
        clks(5);
        wait_rise(ok);
        check("t6 rise found", int'(ok), 1);
        hi  = 1;
        inc = 1'b1;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            hi += int'(o_pwm);
            if (k == 1) inc = 1'b0;
        end
        check("t6 current period", hi, 5);
        window(hi);
        check("t6 next period", hi, 6);

        // Period length stays at 10 clocks.
        wait_rise(ok);
        check("t6 rise found 2", int'(ok), 1);
        rise_dist(d);
        check("period len a", d, 10);
        rise_dist(d);
        check("period len b", d, 10);

        // Reset mid-period: output drops next clock, duty back to 5.
        clks(2);
        check("pre-reset high", int'(o_pwm), 1);
        reset = 1'b0;
        @(negedge clk);
        check("mid reset o_pwm", int'(o_pwm), 0);
        clks(2);
        reset = 1'b1;
        clks(15);
        window(hi);
        check("post reset duty", hi, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
